frame_mem_writer: RTL and testbench
===================================

// Module: frame_mem_writer
// PURPOSE
//  Write side of the frame memory the VGA scanner reads. Takes a pixel stream (valid/ready) and
//  stores it raster-ordered: original image at 0x6 with its side length at header word 0x2, or
//  the interpolated quadrant at 0x3D289. Sits between the image source/interpolation engine and
//  the frame memory write port; the VGA address generator is the consumer.
// PARAMETERS
//  ADDR_W       19        memory address width
//  DATA_W       16        memory word width; pixels zero-extended, header holds dimensiones
//  PIX_W        8         input pixel width
//  DIM_ADDR     19'h2     header word address (original-image side length)
//  ORIG_BASE    19'h6     first pixel address, original image
//  INTERP_BASE  19'h3D289 first pixel address, interpolated quadrant
//  MAX_DIM      16'd392   largest accepted side length
// PORTS
//  clk            in   1       system clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  start          in   1       begin frame; sampled only in IDLE
//  interpolacion  in   1       0 = original image, 1 = interpolated quadrant; sampled with start
//  dimensiones    in   16      original side length; sampled with start
//  in_valid       in   1       pixel present
//  in_data        in   PIX_W   pixel value
//  in_ready       out  1       block accepts pixel this cycle
//  mem_we         out  1       write strobe
//  mem_addr       out  ADDR_W  write address
//  mem_wdata      out  DATA_W  write data
//  busy           out  1       high from start acceptance until done/error
//  done           out  1       one-cycle pulse after last pixel written
//  error          out  1       one-cycle pulse on rejected start
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; in_ready, mem_we, busy, done, error = 0; mem_addr, mem_wdata = 0.
//  - States: IDLE, HDR, PIX, FIN. All outputs registered.
//  - side: interpolacion=0 -> dimensiones; =1 -> 3*(dimensiones>>2)-2, computed 18-bit signed at start.
//  - IDLE + start: error if dimensiones==0, dimensiones>MAX_DIM, or side<1 -> error pulse next cycle,
//    stay IDLE, no mem_we. Else busy=1; interpolacion=0 -> HDR; =1 -> PIX, pointer=INTERP_BASE.
//  - HDR (one cycle): mem_we=1, mem_addr=DIM_ADDR, mem_wdata=dimensiones; pointer=ORIG_BASE; -> PIX.
//  - PIX: in_ready=1. Transfer = in_valid & in_ready. Next cycle: mem_we=1, mem_addr=pointer,
//    mem_wdata={'0,in_data}; pointer++. Latency transfer->write = 1 cycle; back-to-back every cycle.
//    Cycles with no transfer: mem_we=0, pointer held, addresses stay contiguous.
//  - col/row counters 0..side-1; last pixel = col==side-1 && row==side-1. On last transfer in_ready
//    drops next cycle, -> FIN. FIN: done=1 one cycle, busy=0, -> IDLE. done coincides with the cycle
//    after the final mem_we.
//  - start while not IDLE: ignored. dimensiones/interpolacion changes after start: ignored.
//  - Pointer never exceeds base+side*side-1; no wrap. side*side fits within address space by MAX_DIM.
//  - Reset mid-frame: write abandoned immediately, partial frame left in memory; next start restarts at base.
//  - No memory backpressure: memory accepts a write every cycle.
// STRUCTURE
//  - Package frame_mem_pkg: DIM_ADDR, ORIG_BASE, INTERP_BASE, MAX_DIM, state enum typedef,
//    function quad_side(dim) = 3*(dim>>2)-2 (shared with VGA address generator).
//  - One sub-module raster_counter: side-bounded col/row counter with clear, inc, last flag.
// TESTING
//  1. interp=0, dim=4, 16 pixels 0x00..0x0F continuous -> write (0x2,4), then 0x6..0x15 data
//     0x00..0x0F one per cycle; done one cycle after write 0x15; in_ready low after 16th accept.
//  2. interp=1, dim=8 (side=4) -> no header; 16 writes 0x3D289..0x3D298; done pulse.
//  3. dim=4, in_valid toggled 1,0,0,1,... -> only transfers write, addresses contiguous 0x6..0x15.
//  4. start with dim=0, dim=400, interp=1 dim=2 -> error pulse each, busy=0, mem_we never asserted.
//  5. rst_n low after 5 pixels of dim=4 frame -> all outputs 0 immediately; restart writes header then 0x6.
//  6. start pulses and dim changes during PIX -> ignored; frame completes with original side.

Source files
------------

// File: rtl/frame_mem_writer_pkg.sv
// -----------------------------------------------------------------------------
// frame_mem_pkg
// Shared constants, FSM state type and the interpolated-quadrant side helper
// for the frame memory write side. The VGA address generator imports the
// same package so both ends agree on the memory layout.
// -----------------------------------------------------------------------------
package frame_mem_pkg;

    localparam int ADDR_W = 19;  // memory address width
    localparam int DATA_W = 16;  // memory word width
    localparam int PIX_W  = 8;   // input pixel width
    localparam int SIDE_W = 9;   // enough for any accepted side length (<= 392)

    localparam logic [ADDR_W-1:0] DIM_ADDR    = 19'h00002;
    localparam logic [ADDR_W-1:0] ORIG_BASE   = 19'h00006;
    localparam logic [ADDR_W-1:0] INTERP_BASE = 19'h3D289;
    localparam logic [15:0]       MAX_DIM     = 16'd392;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PIX  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Side length of the interpolated quadrant, signed so that tiny inputs
    // produce a negative (rejectable) result instead of wrapping.
    function automatic logic signed [17:0] quad_side(input logic [15:0] dim);
        logic signed [17:0] q_s;
        q_s = signed'({2'b00, (dim >> 2)});
        return (18'sd3 * q_s) - 18'sd2;
    endfunction

endpackage

// File: rtl/frame_mem_writer_if.sv
// -----------------------------------------------------------------------------
// frame_mem_writer_if
// Pixel stream (valid/ready) and frame memory write port bundle.
//   in_valid/in_data  : pixel source -> writer
//   in_ready          : writer -> pixel source
//   mem_we/addr/wdata : writer -> frame memory
// master = pixel source / memory side, slave = the writer.
// -----------------------------------------------------------------------------
interface frame_mem_writer_if #(
    parameter int ADDR_W = frame_mem_pkg::ADDR_W,
    parameter int DATA_W = frame_mem_pkg::DATA_W,
    parameter int PIX_W  = frame_mem_pkg::PIX_W
) ();
    logic              in_valid;
    logic [PIX_W-1:0]  in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/frame_mem_writer_raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Column/row counter bounded by a side length; flags the last raster position.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : return to (0,0)
//   inc_i      : advance one position in raster order
//   side_i     : side length (>= 1)
//   last_o     : current position is (side-1, side-1)
// -----------------------------------------------------------------------------
module raster_counter
    import frame_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [SIDE_W-1:0] side_i,
    output logic              last_o
);
    logic [SIDE_W-1:0] col_q, col_d;
    logic [SIDE_W-1:0] row_q, row_d;
    logic [SIDE_W-1:0] side_m1_s;

    assign side_m1_s = side_i - 9'd1;
    assign last_o    = (col_q == side_m1_s) && (row_q == side_m1_s);

    // Next position: clear wins, otherwise wrap the column into the next row.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (inc_i) begin
            if (col_q == side_m1_s) begin
                col_d = '0;
                row_d = row_q + 9'd1;
            end else begin
                col_d = col_q + 9'd1;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: rtl/frame_mem_writer.sv
// -----------------------------------------------------------------------------
// frame_mem_writer
// Stores a raster-ordered pixel stream into the frame memory read by the VGA
// scanner: either the original image (side length header + pixels) or the
// interpolated quadrant (pixels only).
//   clk, rst_n     : clock, async active-low reset
//   start          : begin a frame (sampled in IDLE only)
//   interpolacion  : 0 = original image, 1 = interpolated quadrant
//   dimensiones    : original side length
//   bus (slave)    : pixel stream in, memory write port out
//   busy           : frame in progress
//   done           : one-cycle pulse after the last pixel write
//   error          : one-cycle pulse on a rejected start
// -----------------------------------------------------------------------------
module frame_mem_writer
    import frame_mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               interpolacion,
    input  logic [15:0]        dimensiones,
    frame_mem_writer_if.slave  bus,
    output logic               busy,
    output logic               done,
    output logic               error
);
    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [SIDE_W-1:0] side_q, side_d;

    logic signed [17:0] side_s;
    logic               bad_s;
    logic               xfer_s;
    logic               last_s;
    logic               cnt_clr_s;
    logic               cnt_inc_s;

    assign side_s = interpolacion ? quad_side(dimensiones)
                                  : signed'({2'b00, dimensiones});
    assign bad_s  = (dimensiones == 16'd0) || (dimensiones > MAX_DIM) || (side_s < 18'sd1);
    // in_ready_q is only ever high in PIX, so this is also the PIX-state transfer.
    assign xfer_s = bus.in_valid & in_ready_q;

    raster_counter u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr_s),
        .inc_i  (cnt_inc_s),
        .side_i (side_q),
        .last_o (last_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !bad_s) begin
                    state_d = interpolacion ? ST_PIX : ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR:  state_d = ST_PIX;
            ST_PIX: begin
                if (xfer_s && last_s) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_PIX;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output/datapath next values; everything below is registered so the
    // values computed here appear on the ports one cycle later.
    always_comb begin
        in_ready_d  = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        ptr_d       = ptr_q;
        side_d      = side_q;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && bad_s) begin
                    error_d = 1'b1;
                end else if (start) begin
                    busy_d    = 1'b1;
                    side_d    = side_s[SIDE_W-1:0];
                    cnt_clr_s = 1'b1;
                    if (interpolacion) begin
                        in_ready_d = 1'b1;
                        ptr_d      = INTERP_BASE;
                    end else begin
                        // Header write is issued while entering HDR.
                        mem_we_d    = 1'b1;
                        mem_addr_d  = DIM_ADDR;
                        mem_wdata_d = dimensiones;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_HDR: begin
                ptr_d      = ORIG_BASE;
                in_ready_d = 1'b1;
            end
            ST_PIX: begin
                if (xfer_s) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = {{(DATA_W-PIX_W){1'b0}}, bus.in_data};
                    cnt_inc_s   = 1'b1;
                    // Hold the pointer on the final pixel so it never passes the frame end.
                    ptr_d       = last_s ? ptr_q : (ptr_q + 19'd1);
                    in_ready_d  = !last_s;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_FIN: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            ptr_q       <= '0;
            side_q      <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            ptr_q       <= ptr_d;
            side_q      <= side_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
endmodule

// File: tb/tb_frame_mem_writer.sv
// -----------------------------------------------------------------------------
// tb_frame_mem_writer
// Randomized frames checked against a write list built from the frame rules:
// optional header (0x2, dim), then base+i <- pixel i for i in 0..side*side-1.
// -----------------------------------------------------------------------------
module tb_frame_mem_writer;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        interpolacion;
    logic [15:0] dimensiones;
    logic        busy;
    logic        done;
    logic        error;

    frame_mem_writer_if bus_if ();

    frame_mem_writer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .interpolacion (interpolacion),
        .dimensiones   (dimensiones),
        .bus           (bus_if.slave),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    int n_checks;
    int n_errors;
    int cyc;

    // observed activity, collected on the falling edge
    logic [34:0] got_q[$];
    int          got_cyc[$];
    int          done_cnt;
    int          done_cyc;
    int          err_cnt;
    int          last_we_cyc;

    logic [34:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // output monitor
    always @(negedge clk) begin
        if (bus_if.mem_we === 1'b1) begin
            got_q.push_back({bus_if.mem_addr, bus_if.mem_wdata});
            got_cyc.push_back(cyc);
            last_we_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (error === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks = n_checks + 1;
        if (obs !== exp_v) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        done_cnt    = 0;
        done_cyc    = -100;
        err_cnt     = 0;
        last_we_cyc = -100;
    endtask

    // Async reset pulse, called #1 after a rising edge; outputs must clear at once.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_ready"}, bus_if.in_ready, 0);
        chk({tag, "_we"},    bus_if.mem_we, 0);
        chk({tag, "_addr"},  bus_if.mem_addr, 0);
        chk({tag, "_wdata"}, bus_if.mem_wdata, 0);
        chk({tag, "_flags"}, {busy, done, error}, 0);
        #2;
        rst_n = 1'b1;
    endtask

    // vmode: 0 continuous, 1 pattern 1,0,0, 2 random; noisy: wiggle start/dim/interp
    // during the frame; stop_at > 0: reset after that many transfers.
    task automatic run_frame(input bit interp, input int dim, input int vmode,
                             input bit noisy, input int stop_at);
        int side, n, base, idx, budget, first;
        bit xfer;
        logic [7:0] pix[$];
        logic [7:0] p;
        clear_obs();
        side = interp ? (3 * (dim / 4) - 2) : dim;
        n    = side * side;
        base = interp ? 32'h3D289 : 32'h6;
        if (!interp) exp_q.push_back({19'h2, dim[15:0]});
        for (int i = 0; i < n; i++) begin
            p = 8'($urandom);
            pix.push_back(p);
            exp_q.push_back({19'(base + i), 8'h00, p});
        end
        @(posedge clk); #1;
        start = 1'b1; interpolacion = interp; dimensiones = dim[15:0];
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start", busy, 1);
        idx = 0; budget = 0;
        while (idx < n && budget < 4000 && !(stop_at > 0 && idx == stop_at)) begin
            case (vmode)
                0:       bus_if.in_valid = 1'b1;
                1:       bus_if.in_valid = (budget % 3 == 0);
                default: bus_if.in_valid = 1'($urandom_range(0, 1));
            endcase
            bus_if.in_data = pix[idx];
            if (noisy) begin
                start         = 1'($urandom_range(0, 1));
                dimensiones   = 16'($urandom);
                interpolacion = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            xfer = bus_if.in_valid && bus_if.in_ready;
            @(posedge clk); #1;
            if (xfer) idx++;
            budget++;
        end
        bus_if.in_valid = 1'b0;
        start = 1'b0;
        if (stop_at > 0) begin
            do_reset("mid_rst");
            return;
        end
        chk("xfer_count", idx, n);
        chk("ready_drop", bus_if.in_ready, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("done_cnt", done_cnt, 1);
        chk("done_lat", done_cyc - last_we_cyc, 1);
        chk("busy_end", busy, 0);
        chk("err_none", err_cnt, 0);
        chk("n_writes", got_q.size(), exp_q.size());
        if (got_q.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++) chk("write", got_q[i], exp_q[i]);
            first = interp ? 0 : 1;
            if (vmode == 0 && n > 0)
                chk("back2back", got_cyc[got_cyc.size()-1] - got_cyc[first], n - 1);
        end
    endtask

    task automatic run_err(input bit interp, input int dim);
        clear_obs();
        @(posedge clk); #1;
        start = 1'b1; interpolacion = interp; dimensiones = dim[15:0];
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", error, 1);
        chk("err_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_once", err_cnt, 1);
        chk("err_no_we", got_q.size(), 0);
        chk("err_idle", {busy, error}, 0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0; interpolacion = 1'b0; dimensiones = 16'd0;
        bus_if.in_valid = 1'b0; bus_if.in_data = 8'h00;
        clear_obs();
        #12;
        chk("rst_ready", bus_if.in_ready, 0);
        chk("rst_we",    bus_if.mem_we, 0);
        chk("rst_addr",  bus_if.mem_addr, 0);
        chk("rst_wdata", bus_if.mem_wdata, 0);
        chk("rst_flags", {busy, done, error}, 0);
        rst_n = 1'b1;

        // directed frames
        run_frame(1'b0, 4, 0, 1'b0, 0);     // original 4x4, continuous
        run_frame(1'b1, 8, 0, 1'b0, 0);     // quadrant side 4
        run_frame(1'b0, 4, 1, 1'b0, 0);     // gapped valid
        run_frame(1'b1, 4, 2, 1'b0, 0);     // smallest quadrant: side 1
        run_frame(1'b0, 1, 0, 1'b0, 0);     // smallest original
        // rejected starts
        run_err(1'b0, 0);
        run_err(1'b0, 400);
        run_err(1'b0, 393);
        run_err(1'b1, 2);
        run_err(1'b1, 0);
        // largest accepted side starts a frame; abandon it with reset
        clear_obs();
        @(posedge clk); #1;
        start = 1'b1; interpolacion = 1'b0; dimensiones = 16'd392;
        @(posedge clk); #1;
        start = 1'b0;
        chk("max_busy", busy, 1);
        chk("max_no_err", error, 0);
        do_reset("max_rst");
        // reset mid-frame, then a clean restart from the header
        run_frame(1'b0, 4, 0, 1'b0, 5);
        run_frame(1'b0, 4, 0, 1'b0, 0);
        // start/dim/interp noise during the frame
        run_frame(1'b0, 5, 2, 1'b1, 0);
        run_frame(1'b1, 12, 0, 1'b1, 0);
        // random frames
        for (int k = 0; k < 6; k++) begin
            bit ri;
            ri = 1'($urandom_range(0, 1));
            run_frame(ri, ri ? $urandom_range(4, 22) : $urandom_range(1, 10),
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
